sprite_unit: RTL and testbench
==============================

Name: sprite_unit

Overview:
- Downstream consumer of the SPI receiver's sprite and position strobes. Holds an 8x8 1-bit sprite bitmap and a sprite X/Y position, all loaded serially from the SPI data bit.
- Stages updates into shadow registers and commits them atomically at frame start, so the display never shows a partially loaded sprite.
- Renders a registered per-pixel sprite bit for the pixel pipeline.
- Echoes the outgoing bitmap bit back to the SPI receiver for readback.

Parameters:
- POS_W, 10, width of the X/Y position registers and of the pixel coordinates.
- SCALE, 2, log2 of the on-screen size of one sprite bit; each bit covers (1<<SCALE) x (1<<SCALE) screen pixels.
- BITMAP_DEFAULT, 64'h0, reset value of the staging and active bitmap.
- X_DEFAULT, 0, reset value of the staging and active X position.
- Y_DEFAULT, 0, reset value of the staging and active Y position.

Ports:
- clk  input  1  system clock, the only clock.
- reset  input  1  asynchronous, active-high reset.
- spi_sprite_shift  input  1  one-cycle strobe: shift spi_mosi_sync into the staging bitmap.
- spi_sprite_mode  input  1  high while a sprite bitmap load is in progress.
- spi_mosi_sync  input  1  synchronized serial data bit.
- shift_x  input  1  one-cycle strobe: shift spi_mosi_sync into the staging X position.
- shift_y  input  1  one-cycle strobe: shift spi_mosi_sync into the staging Y position.
- sprite_data  output  1  bit currently at staging bitmap MSB, used for SPI readback echo.
- frame_start  input  1  one-cycle strobe at the first cycle of each frame.
- pixel_en  input  1  current pixel coordinates are valid (visible area).
- pixel_x  input  POS_W  current pixel column.
- pixel_y  input  POS_W  current pixel row.
- sprite_pixel  output  1  registered sprite bit for the pixel presented one cycle earlier.
- sprite_pixel_valid  output  1  registered copy of pixel_en, aligned with sprite_pixel.
- commit_pending  output  1  a frame-start commit was deferred and is still outstanding.

Behaviour:
- Reset (async, active-high):
  - Staging and active bitmap load BITMAP_DEFAULT.
  - Staging and active X/Y load X_DEFAULT/Y_DEFAULT.
  - sprite_pixel, sprite_pixel_valid, commit_pending and the internal dirty flag are 0.
  - Reset asserted mid-load discards all partial staging data.
- Bitmap shift:
  - On spi_sprite_shift: staging_bitmap <= {staging_bitmap[62:0], spi_mosi_sync}; dirty <= 1.
  - sprite_data = staging_bitmap[63], combinational.
  - After 64 shifts, the first bit shifted in sits at bit 63 = row 0, column 0 (top-left).
  - Bitmap bit for row r, column c is bitmap[63 - (8*r + c)].
- Position shift:
  - shift_x: staging_x <= {staging_x[POS_W-2:0], spi_mosi_sync}; dirty <= 1. MSB first; bits beyond POS_W fall off the top.
  - shift_y: same, on staging_y.
  - Simultaneous strobes each act on their own register in the same cycle.
- Commit control, evaluated every cycle on the cycle frame_start=1:
  - If dirty=1 and spi_sprite_mode=0: copy staging bitmap, X and Y to the active registers; clear dirty and commit_pending.
  - If dirty=1 and spi_sprite_mode=1: no copy; set commit_pending=1.
  - If commit_pending=1 and frame_start=0: the commit fires on the first cycle spi_sprite_mode=0. It is not deferred to the next frame start.
  - A shift strobe in the same cycle as a commit is applied to staging after the copy, so the copy takes the pre-shift value, and it re-sets dirty.
  - If dirty=0, frame_start has no effect.
- Render, active registers only:
  - dx = pixel_x - active_x and dy = pixel_y - active_y, both computed in POS_W+1 bits.
  - Hit when both differences are non-negative and < (8<<SCALE).
  - No wrap-around: a sprite near the right or bottom edge is clipped, never wrapped.
  - Column = dx[SCALE+2:SCALE]; row = dy[SCALE+2:SCALE].
  - Each cycle: sprite_pixel <= pixel_en & hit & bitmap[63-(8*row+col)]; sprite_pixel_valid <= pixel_en.
  - Latency is exactly 1 cycle.
  - A commit in cycle N affects the render from pixels presented in cycle N+1 onward.

Test Plan:
- Reset mid-load: assert reset after 17 bitmap shifts -> staging/active bitmap = BITMAP_DEFAULT, all outputs 0; the next frame_start commits nothing.
- Bitmap load and commit: shift 64 bits, pattern 0x8000_0000_0000_0001, with spi_sprite_mode high, drop mode, pulse frame_start, X=Y=0, SCALE=2 -> sprite_pixel=1 one cycle after (0,0)..(3,3) and after (28..31,28..31); 0 elsewhere; 0 at (32,0).
- Position load: shift X=10'd100, Y=10'd50 MSB first, commit -> (100,50) hits; (99,50) and (100,49) miss; (131,81) hits; (132,50) misses.
- Deferred commit: frame_start while spi_sprite_mode=1 and dirty -> commit_pending=1, active unchanged; drop spi_sprite_mode 5 cycles later -> commit that cycle, commit_pending=0.
- Edge clip: X=10'd1020, all-ones bitmap -> hits at x=1020..1023 only; x=0..27 on the same rows never hit.
- Readback echo: after loading 0xA5 in the top byte, each spi_sprite_shift -> sprite_data presents 1,0,1,0,0,1,0,1 in order; pixel_en=0 -> sprite_pixel and sprite_pixel_valid both 0 next cycle.

Source files
------------

// File: rtl/sprite_unit.sv
// sprite_unit: 8x8 1-bit sprite with serially loaded bitmap and X/Y position.
// Serial updates land in staging registers and are copied to the active
// registers atomically at frame start, or as soon as the sprite load ends if
// the frame-start commit had to be deferred. The active registers drive a
// one-cycle-latency per-pixel renderer.
module sprite_unit #(
  parameter int                POS_W          = 10,
  parameter int                SCALE          = 2,
  parameter logic [63:0]       BITMAP_DEFAULT = 64'h0,
  parameter logic [POS_W-1:0]  X_DEFAULT      = {POS_W{1'b0}},
  parameter logic [POS_W-1:0]  Y_DEFAULT      = {POS_W{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spi_sprite_shift,
  input  logic             spi_sprite_mode,
  input  logic             spi_mosi_sync,
  input  logic             shift_x,
  input  logic             shift_y,
  output logic             sprite_data,
  input  logic             frame_start,
  input  logic             pixel_en,
  input  logic [POS_W-1:0] pixel_x,
  input  logic [POS_W-1:0] pixel_y,
  output logic             sprite_pixel,
  output logic             sprite_pixel_valid,
  output logic             commit_pending
);

  // On-screen extent of the sprite along each axis, in pixels.
  localparam logic [POS_W:0] SPAN = (POS_W+1)'(8 << SCALE);

  // Bitmap bit for (row, col); row 0 / col 0 lives at bit 63.
  function automatic logic bitmap_bit(input logic [63:0] bm,
                                      input logic [2:0]  row,
                                      input logic [2:0]  col);
    logic [5:0] idx;
    idx = ~{row, col};
    return bm[idx];
  endfunction

  logic [63:0]      r_stage_bm;
  logic [63:0]      r_act_bm;
  logic [POS_W-1:0] r_stage_x;
  logic [POS_W-1:0] r_stage_y;
  logic [POS_W-1:0] r_act_x;
  logic [POS_W-1:0] r_act_y;
  logic             r_dirty;
  logic             r_pending;
  logic             r_pix;
  logic             r_pix_valid;

  logic             w_commit;
  logic             w_defer;
  logic             w_any_shift;
  logic [POS_W:0]   w_dx;
  logic [POS_W:0]   w_dy;
  logic             w_hit;
  logic             w_bit;

  assign sprite_data        = r_stage_bm[63];
  assign sprite_pixel       = r_pix;
  assign sprite_pixel_valid = r_pix_valid;
  assign commit_pending     = r_pending;

  // Commit decision: fire at frame start or on a pending commit once the load ends.
  always_comb begin
    w_commit    = 1'b0;
    w_defer     = 1'b0;
    w_any_shift = spi_sprite_shift | shift_x | shift_y;
    if (r_dirty && !spi_sprite_mode && (frame_start || r_pending)) begin
      w_commit = 1'b1;
    end else if (r_dirty && spi_sprite_mode && frame_start) begin
      w_defer = 1'b1;
    end else begin
      w_commit = 1'b0;
      w_defer  = 1'b0;
    end
  end

  // Sprite-relative coordinates and bitmap lookup; negative offsets wrap to
  // large unsigned values and therefore fail the span compare (clip, no wrap).
  always_comb begin
    w_dx  = {1'b0, pixel_x} - {1'b0, r_act_x};
    w_dy  = {1'b0, pixel_y} - {1'b0, r_act_y};
    w_hit = 1'b0;
    w_bit = 1'b0;
    if ((w_dx < SPAN) && (w_dy < SPAN)) begin
      w_hit = 1'b1;
      w_bit = bitmap_bit(r_act_bm, w_dy[SCALE+2:SCALE], w_dx[SCALE+2:SCALE]);
    end else begin
      w_hit = 1'b0;
      w_bit = 1'b0;
    end
  end

  // Staging shift registers, MSB first from the SPI data bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage_bm <= BITMAP_DEFAULT;
      r_stage_x  <= X_DEFAULT;
      r_stage_y  <= Y_DEFAULT;
    end else begin
      if (spi_sprite_shift) begin
        r_stage_bm <= {r_stage_bm[62:0], spi_mosi_sync};
      end
      if (shift_x) begin
        r_stage_x <= {r_stage_x[POS_W-2:0], spi_mosi_sync};
      end
      if (shift_y) begin
        r_stage_y <= {r_stage_y[POS_W-2:0], spi_mosi_sync};
      end
    end
  end

  // Active registers take the pre-shift staging value on commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_bm <= BITMAP_DEFAULT;
      r_act_x  <= X_DEFAULT;
      r_act_y  <= Y_DEFAULT;
    end else if (w_commit) begin
      r_act_bm <= r_stage_bm;
      r_act_x  <= r_stage_x;
      r_act_y  <= r_stage_y;
    end
  end

  // Dirty and pending flags; a shift coinciding with a commit re-dirties staging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dirty   <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (w_any_shift) begin
        r_dirty <= 1'b1;
      end else if (w_commit) begin
        r_dirty <= 1'b0;
      end
      if (w_commit) begin
        r_pending <= 1'b0;
      end else if (w_defer) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Registered render output, one cycle after the pixel is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix       <= 1'b0;
      r_pix_valid <= 1'b0;
    end else begin
      r_pix       <= pixel_en & w_hit & w_bit;
      r_pix_valid <= pixel_en;
    end
  end

endmodule

// File: tb/tb_sprite_unit.sv
// Directed testbench for sprite_unit with immediate-assertion checks.
module tb_sprite_unit;

  logic       clk;
  logic       reset;
  logic       spi_sprite_shift;
  logic       spi_sprite_mode;
  logic       spi_mosi_sync;
  logic       shift_x;
  logic       shift_y;
  logic       sprite_data;
  logic       frame_start;
  logic       pixel_en;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       sprite_pixel;
  logic       sprite_pixel_valid;
  logic       commit_pending;

  int n_cmp = 0;
  int n_err = 0;

  sprite_unit dut (
    .clk                (clk),
    .reset              (reset),
    .spi_sprite_shift   (spi_sprite_shift),
    .spi_sprite_mode    (spi_sprite_mode),
    .spi_mosi_sync      (spi_mosi_sync),
    .shift_x            (shift_x),
    .shift_y            (shift_y),
    .sprite_data        (sprite_data),
    .frame_start        (frame_start),
    .pixel_en           (pixel_en),
    .pixel_x            (pixel_x),
    .pixel_y            (pixel_y),
    .sprite_pixel       (sprite_pixel),
    .sprite_pixel_valid (sprite_pixel_valid),
    .commit_pending     (commit_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bm(input logic b);
    spi_mosi_sync = b;
    spi_sprite_shift = 1'b1;
    tick();
    spi_sprite_shift = 1'b0;
  endtask

  task automatic load_bm(input logic [63:0] v);
    for (int i = 63; i >= 0; i--) shift_bm(v[i]);
  endtask

  task automatic load_x(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      spi_mosi_sync = v[i];
      shift_x = 1'b1;
      tick();
      shift_x = 1'b0;
    end
  endtask

  task automatic load_y(input logic [9:0] v);
    for (int i = 9; i >= 0; i--) begin
      spi_mosi_sync = v[i];
      shift_y = 1'b1;
      tick();
      shift_y = 1'b0;
    end
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic exp);
    pixel_en = 1'b1;
    pixel_x  = x;
    pixel_y  = y;
    tick();
    pixel_en = 1'b0;
    chk(tag, {63'd0, sprite_pixel}, {63'd0, exp});
    chk({tag, "_valid"}, {63'd0, sprite_pixel_valid}, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    spi_sprite_shift = 1'b0;
    spi_sprite_mode  = 1'b0;
    spi_mosi_sync    = 1'b0;
    shift_x          = 1'b0;
    shift_y          = 1'b0;
    frame_start      = 1'b0;
    pixel_en         = 1'b0;
    pixel_x          = 10'd0;
    pixel_y          = 10'd0;
    tick();
    tick();
    chk("rst_pixel",   {63'd0, sprite_pixel},       64'd0);
    chk("rst_valid",   {63'd0, sprite_pixel_valid}, 64'd0);
    chk("rst_pending", {63'd0, commit_pending},     64'd0);
    chk("rst_sdata",   {63'd0, sprite_data},        64'd0);
    reset = 1'b0;
    tick();

    // Reset mid-load discards staging and clears dirty.
    spi_sprite_mode = 1'b1;
    for (int i = 0; i < 17; i++) shift_bm(1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_sdata",   {63'd0, sprite_data},    64'd0);
    chk("midrst_pending", {63'd0, commit_pending}, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    pulse_frame();
    chk("midrst_nocommit", {63'd0, commit_pending}, 64'd0);
    spi_sprite_mode = 1'b0;
    tick();
    probe("midrst_px00", 10'd0, 10'd0, 1'b0);

    // Bitmap load with corner bits, committed at frame start.
    spi_sprite_mode = 1'b1;
    load_bm(64'h8000_0000_0000_0001);
    chk("bm_sdata_msb", {63'd0, sprite_data}, 64'd1);
    spi_sprite_mode = 1'b0;
    tick();
    probe("bm_precommit", 10'd0, 10'd0, 1'b0);
    pulse_frame();
    chk("bm_pending", {63'd0, commit_pending}, 64'd0);
    probe("bm_0_0",   10'd0,  10'd0,  1'b1);
    probe("bm_3_3",   10'd3,  10'd3,  1'b1);
    probe("bm_4_0",   10'd4,  10'd0,  1'b0);
    probe("bm_0_4",   10'd0,  10'd4,  1'b0);
    probe("bm_28_28", 10'd28, 10'd28, 1'b1);
    probe("bm_31_31", 10'd31, 10'd31, 1'b1);
    probe("bm_27_31", 10'd27, 10'd31, 1'b0);
    probe("bm_32_0",  10'd32, 10'd0,  1'b0);

    // Position load.
    load_x(10'd100);
    load_y(10'd50);
    probe("pos_precommit", 10'd100, 10'd50, 1'b0);
    pulse_frame();
    probe("pos_100_50", 10'd100, 10'd50, 1'b1);
    probe("pos_99_50",  10'd99,  10'd50, 1'b0);
    probe("pos_100_49", 10'd100, 10'd49, 1'b0);
    probe("pos_131_81", 10'd131, 10'd81, 1'b1);
    probe("pos_132_50", 10'd132, 10'd50, 1'b0);
    probe("pos_104_50", 10'd104, 10'd50, 1'b0);

    // Deferred commit of an all-ones bitmap.
    spi_sprite_mode = 1'b1;
    load_bm(64'hFFFF_FFFF_FFFF_FFFF);
    pulse_frame();
    chk("def_pending_set", {63'd0, commit_pending}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      probe("def_hold_px", 10'd104, 10'd50, 1'b0);
      chk("def_hold_pending", {63'd0, commit_pending}, 64'd1);
    end
    spi_sprite_mode = 1'b0;
    probe("def_commit_cycle_px", 10'd104, 10'd50, 1'b0);
    chk("def_pending_clr", {63'd0, commit_pending}, 64'd0);
    probe("def_after_px", 10'd104, 10'd50, 1'b1);

    // Right-edge clip.
    load_x(10'd1020);
    load_y(10'd0);
    pulse_frame();
    probe("clip_1020_0",  10'd1020, 10'd0,  1'b1);
    probe("clip_1023_0",  10'd1023, 10'd0,  1'b1);
    probe("clip_1023_31", 10'd1023, 10'd31, 1'b1);
    probe("clip_1019_0",  10'd1019, 10'd0,  1'b0);
    probe("clip_0_0",     10'd0,    10'd0,  1'b0);
    probe("clip_27_5",    10'd27,   10'd5,  1'b0);
    probe("clip_1023_32", 10'd1023, 10'd32, 1'b0);

    // Readback echo of 0xA5 in the top byte.
    load_bm(64'hA500_0000_0000_0000);
    begin
      logic [7:0] echo;
      echo = 8'hA5;
      for (int i = 7; i >= 0; i--) begin
        chk("echo_bit", {63'd0, sprite_data}, {63'd0, echo[i]});
        shift_bm(1'b0);
      end
    end

    // pixel_en low suppresses both outputs even on a hit location.
    pixel_en = 1'b0;
    pixel_x  = 10'd1020;
    pixel_y  = 10'd0;
    tick();
    chk("noen_pixel", {63'd0, sprite_pixel},       64'd0);
    chk("noen_valid", {63'd0, sprite_pixel_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
